// File: rtl/alu_regfile_defs.sv
// Shared definitions for the ALU / register-file pair and its command sequencer:
// data and address widths, the ALU opcode type, the sequencer state encoding
// and the packed register-level command payload.
package alu_regfile_defs;

    localparam int unsigned REGFILE_WIDTH      = 8;
    localparam int unsigned REGFILE_ADDR_WIDTH = 3;
    localparam int unsigned ALU_OP_WIDTH       = 3;

    typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } seq_state_t;

    // One register-level command as presented on the Cmd_* handshake
    typedef struct packed {
        logic                          load;
        alu_op_t                       op;
        logic [REGFILE_ADDR_WIDTH-1:0] src1;
        logic [REGFILE_ADDR_WIDTH-1:0] src2;
        logic [REGFILE_ADDR_WIDTH-1:0] dst;
        logic [REGFILE_WIDTH-1:0]      imm;
    } seq_cmd_t;

endpackage

// File: rtl/regfile_sequencer.sv
// Command-driven initiator for a dual-read/single-write register file.
// Accepts one command per Cmd_Valid/Cmd_Ready handshake and walks it through
// READ (operand fetch), EXEC (ALU result capture) and WB (register write).
// Load commands skip straight to WB and write the immediate.
//
// Ports:
//   Clock, Reset                    clock and synchronous active-high reset
//   Cmd_Valid/Cmd_Ready             command handshake
//   Cmd_Load/Op/Src1/Src2/Dst/Imm   command fields, latched on accept
//   Read_Addr_1/2, Rd_Data_1/2      register file read ports (combinational read)
//   Rf_Write_Addr/Data/enable       register file write port
//   Alu_A/Alu_B/Alu_Op, Alu_Result  external combinational ALU
//   Done                            high during the write-back cycle
//   Result                          last written value
module regfile_sequencer
    import alu_regfile_defs::*;
#(
    parameter int unsigned DATA_WIDTH = REGFILE_WIDTH,
    parameter int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH,
    parameter int unsigned OP_WIDTH   = ALU_OP_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Cmd_Valid,
    output logic                  Cmd_Ready,
    input  logic                  Cmd_Load,
    input  logic [OP_WIDTH-1:0]   Cmd_Op,
    input  logic [ADDR_WIDTH-1:0] Cmd_Src1,
    input  logic [ADDR_WIDTH-1:0] Cmd_Src2,
    input  logic [ADDR_WIDTH-1:0] Cmd_Dst,
    input  logic [DATA_WIDTH-1:0] Cmd_Imm,
    output logic [ADDR_WIDTH-1:0] Read_Addr_1,
    output logic [ADDR_WIDTH-1:0] Read_Addr_2,
    input  logic [DATA_WIDTH-1:0] Rd_Data_1,
    input  logic [DATA_WIDTH-1:0] Rd_Data_2,
    output logic [ADDR_WIDTH-1:0] Rf_Write_Addr,
    output logic [DATA_WIDTH-1:0] Rf_Write_Data,
    output logic                  Rf_Write_enable,
    output logic [DATA_WIDTH-1:0] Alu_A,
    output logic [DATA_WIDTH-1:0] Alu_B,
    output logic [OP_WIDTH-1:0]   Alu_Op,
    input  logic [DATA_WIDTH-1:0] Alu_Result,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result
);

    seq_state_t state;
    seq_state_t next_state;
    logic       accept;

    logic                  load_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] result_q;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake/strobe outputs; Reset gates the strobes so a
    // reset landing in WB suppresses the write in that same cycle.
    always_comb begin
        next_state      = state;
        accept          = 1'b0;
        Cmd_Ready       = 1'b0;
        Rf_Write_enable = 1'b0;
        Done            = 1'b0;
        case (state)
            IDLE: begin
                Cmd_Ready = !Reset;
                if (Cmd_Valid && !Reset) begin
                    accept     = 1'b1;
                    next_state = Cmd_Load ? WB : READ;
                end
            end
            READ: next_state = EXEC;
            EXEC: next_state = WB;
            WB: begin
                Rf_Write_enable = !Reset;
                Done            = !Reset;
                next_state      = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Command latch and operand/result datapath
    always_ff @(posedge Clock) begin
        if (Reset) begin
            load_q      <= 1'b0;
            op_q        <= '0;
            dst_q       <= '0;
            imm_q       <= '0;
            result_q    <= '0;
            Read_Addr_1 <= '0;
            Read_Addr_2 <= '0;
            Alu_A       <= '0;
            Alu_B       <= '0;
            Alu_Op      <= '0;
            Result      <= '0;
        end else begin
            if (accept) begin
                load_q <= Cmd_Load;
                op_q   <= Cmd_Op;
                dst_q  <= Cmd_Dst;
                imm_q  <= Cmd_Imm;
                // Read addresses double as the latched sources; loads leave them untouched
                if (!Cmd_Load) begin
                    Read_Addr_1 <= Cmd_Src1;
                    Read_Addr_2 <= Cmd_Src2;
                end
            end
            if (state == READ) begin
                Alu_A  <= Rd_Data_1;
                Alu_B  <= Rd_Data_2;
                Alu_Op <= op_q;
            end
            if (state == EXEC) begin
                result_q <= Alu_Result;
            end
            if (state == WB) begin
                Result <= Rf_Write_Data;
            end
        end
    end

    assign Rf_Write_Addr = dst_q;
    assign Rf_Write_Data = load_q ? imm_q : result_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: models the register file and ALU
// around the DUT and checks every command against an architectural register model.
module tb_regfile_sequencer;
    import alu_regfile_defs::*;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Cmd_Valid;
    logic       Cmd_Ready;
    logic       Cmd_Load;
    logic [2:0] Cmd_Op;
    logic [2:0] Cmd_Src1;
    logic [2:0] Cmd_Src2;
    logic [2:0] Cmd_Dst;
    logic [7:0] Cmd_Imm;
    logic [2:0] Read_Addr_1;
    logic [2:0] Read_Addr_2;
    logic [7:0] Rd_Data_1;
    logic [7:0] Rd_Data_2;
    logic [2:0] Rf_Write_Addr;
    logic [7:0] Rf_Write_Data;
    logic       Rf_Write_enable;
    logic [7:0] Alu_A;
    logic [7:0] Alu_B;
    logic [2:0] Alu_Op;
    logic [7:0] Alu_Result;
    logic       Done;
    logic [7:0] Result;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rf      [8];
    logic [7:0] ref_reg [8];

    always #5 Clock = ~Clock;

    regfile_sequencer dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Cmd_Valid       (Cmd_Valid),
        .Cmd_Ready       (Cmd_Ready),
        .Cmd_Load        (Cmd_Load),
        .Cmd_Op          (Cmd_Op),
        .Cmd_Src1        (Cmd_Src1),
        .Cmd_Src2        (Cmd_Src2),
        .Cmd_Dst         (Cmd_Dst),
        .Cmd_Imm         (Cmd_Imm),
        .Read_Addr_1     (Read_Addr_1),
        .Read_Addr_2     (Read_Addr_2),
        .Rd_Data_1       (Rd_Data_1),
        .Rd_Data_2       (Rd_Data_2),
        .Rf_Write_Addr   (Rf_Write_Addr),
        .Rf_Write_Data   (Rf_Write_Data),
        .Rf_Write_enable (Rf_Write_enable),
        .Alu_A           (Alu_A),
        .Alu_B           (Alu_B),
        .Alu_Op          (Alu_Op),
        .Alu_Result      (Alu_Result),
        .Done            (Done),
        .Result          (Result)
    );

    // External ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass A
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
        case (op)
            3'd0:    return 8'(a + b);
            3'd1:    return 8'(a - b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // Register file peripheral: combinational read, clocked write
    assign Rd_Data_1  = rf[Read_Addr_1];
    assign Rd_Data_2  = rf[Read_Addr_2];
    assign Alu_Result = alu_model(Alu_A, Alu_B, Alu_Op);

    always @(posedge Clock) begin
        if (Rf_Write_enable) rf[Rf_Write_Addr] <= Rf_Write_Data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command starting at a negedge; checks cycle-by-cycle behaviour.
    // keep_valid leaves Cmd_Valid high with scrambled fields while busy.
    // abort_wb asserts Reset during the write-back cycle.
    task automatic do_cmd(input seq_cmd_t cmd, input bit keep_valid, input bit abort_wb);
        logic [7:0] a, b, exp;
        int n;
        a   = ref_reg[cmd.src1];
        b   = ref_reg[cmd.src2];
        exp = cmd.load ? cmd.imm : alu_model(a, b, cmd.op);

        Cmd_Valid = 1'b1;
        Cmd_Load  = cmd.load;
        Cmd_Op    = cmd.op;
        Cmd_Src1  = cmd.src1;
        Cmd_Src2  = cmd.src2;
        Cmd_Dst   = cmd.dst;
        Cmd_Imm   = cmd.imm;
        #1;
        n = 0;
        while (!Cmd_Ready && n < 20) begin
            @(negedge Clock);
            n++;
        end
        if (!Cmd_Ready) begin
            check("ready_wait", 32'(Cmd_Ready), 32'd1);
            Cmd_Valid = 1'b0;
            return;
        end

        @(posedge Clock);
        @(negedge Clock);
        if (keep_valid) begin
            Cmd_Load = 1'($urandom);
            Cmd_Op   = 3'($urandom);
            Cmd_Src1 = 3'($urandom);
            Cmd_Src2 = 3'($urandom);
            Cmd_Dst  = 3'($urandom);
            Cmd_Imm  = 8'($urandom);
        end else begin
            Cmd_Valid = 1'b0;
        end

        if (!cmd.load) begin
            check("read_addr_1", 32'(Read_Addr_1), 32'(cmd.src1));
            check("read_addr_2", 32'(Read_Addr_2), 32'(cmd.src2));
            check("read_done", 32'(Done), 32'd0);
            check("read_ready", 32'(Cmd_Ready), 32'd0);
            @(negedge Clock);
            check("alu_a", 32'(Alu_A), 32'(a));
            check("alu_b", 32'(Alu_B), 32'(b));
            check("alu_op", 32'(Alu_Op), 32'(cmd.op));
            check("exec_wen", 32'(Rf_Write_enable), 32'd0);
            @(negedge Clock);
        end

        if (abort_wb) begin
            Reset = 1'b1;
            #1;
            check("abort_wen", 32'(Rf_Write_enable), 32'd0);
            check("abort_done", 32'(Done), 32'd0);
            check("abort_ready", 32'(Cmd_Ready), 32'd0);
            @(negedge Clock);
            Reset = 1'b0;
            #1;
            check("abort_idle_ready", 32'(Cmd_Ready), 32'd1);
            check("abort_result", 32'(Result), 32'd0);
            check("abort_alu_a", 32'(Alu_A), 32'd0);
            check("abort_no_write", 32'(rf[cmd.dst]), 32'(ref_reg[cmd.dst]));
            return;
        end

        check("wb_done", 32'(Done), 32'd1);
        check("wb_wen", 32'(Rf_Write_enable), 32'd1);
        check("wb_addr", 32'(Rf_Write_Addr), 32'(cmd.dst));
        check("wb_data", 32'(Rf_Write_Data), 32'(exp));
        check("wb_ready", 32'(Cmd_Ready), 32'd0);
        @(negedge Clock);
        check("ret_ready", 32'(Cmd_Ready), 32'd1);
        check("ret_done", 32'(Done), 32'd0);
        check("ret_result", 32'(Result), 32'(exp));
        check("ret_reg", 32'(rf[cmd.dst]), 32'(exp));
        ref_reg[cmd.dst] = exp;
    endtask

    function automatic seq_cmd_t mk(input bit load, input logic [2:0] op, input logic [2:0] s1,
                                    input logic [2:0] s2, input logic [2:0] dst,
                                    input logic [7:0] imm);
        seq_cmd_t c;
        c.load = load; c.op = op; c.src1 = s1; c.src2 = s2; c.dst = dst; c.imm = imm;
        return c;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seq_cmd_t c;
        for (int i = 0; i < 8; i++) begin
            rf[i]      = 8'h00;
            ref_reg[i] = 8'h00;
        end
        Reset     = 1'b1;
        Cmd_Valid = 1'b1;
        Cmd_Load  = 1'b0;
        Cmd_Op    = '0;
        Cmd_Src1  = '0;
        Cmd_Src2  = '0;
        Cmd_Dst   = '0;
        Cmd_Imm   = '0;

        repeat (3) @(negedge Clock);
        check("rst_ready", 32'(Cmd_Ready), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_wen", 32'(Rf_Write_enable), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        check("rst_alu_a", 32'(Alu_A), 32'd0);
        check("rst_alu_b", 32'(Alu_B), 32'd0);
        check("rst_alu_op", 32'(Alu_Op), 32'd0);
        check("rst_raddr1", 32'(Read_Addr_1), 32'd0);
        check("rst_raddr2", 32'(Read_Addr_2), 32'd0);
        check("rst_waddr", 32'(Rf_Write_Addr), 32'd0);
        check("rst_wdata", 32'(Rf_Write_Data), 32'd0);
        Cmd_Valid = 1'b0;
        Reset     = 1'b0;
        #1;
        check("post_rst_ready", 32'(Cmd_Ready), 32'd1);
        @(negedge Clock);

        // Directed sequence
        do_cmd(mk(1'b1, 3'd0, 3'd0, 3'd0, 3'd1, 8'h05), 1'b0, 1'b0);
        do_cmd(mk(1'b1, 3'd0, 3'd0, 3'd0, 3'd2, 8'h03), 1'b0, 1'b0);
        check("result_after_loads", 32'(Result), 32'h03);
        check("r1_loaded", 32'(rf[1]), 32'h05);
        check("r2_loaded", 32'(rf[2]), 32'h03);
        do_cmd(mk(1'b0, 3'd0, 3'd1, 3'd2, 3'd3, 8'h00), 1'b0, 1'b0);
        check("r3_add", 32'(rf[3]), 32'h08);
        do_cmd(mk(1'b0, 3'd1, 3'd3, 3'd3, 3'd3, 8'h00), 1'b0, 1'b0);
        check("r3_self_sub", 32'(rf[3]), 32'h00);
        do_cmd(mk(1'b0, 3'd0, 3'd3, 3'd1, 3'd4, 8'h00), 1'b1, 1'b0);
        do_cmd(mk(1'b0, 3'd0, 3'd4, 3'd4, 3'd5, 8'h00), 1'b1, 1'b0);
        Cmd_Valid = 1'b0;
        check("r4_dep", 32'(rf[4]), 32'h05);
        check("r5_dep", 32'(rf[5]), 32'h0A);
        do_cmd(mk(1'b0, 3'd0, 3'd1, 3'd2, 3'd6, 8'h00), 1'b0, 1'b1);
        check("r6_kept", 32'(rf[6]), 32'h00);
        do_cmd(mk(1'b1, 3'd0, 3'd0, 3'd0, 3'd7, 8'hFF), 1'b0, 1'b0);
        do_cmd(mk(1'b0, 3'd0, 3'd7, 3'd7, 3'd7, 8'h00), 1'b0, 1'b0);
        check("r7_wrap", 32'(rf[7]), 32'hFE);

        // Randomized commands against the architectural model
        repeat (150) begin
            c = mk(($urandom_range(0, 9) < 3), 3'($urandom), 3'($urandom), 3'($urandom),
                   3'($urandom), 8'($urandom));
            do_cmd(c, 1'($urandom), ($urandom_range(0, 19) == 0));
        end
        Cmd_Valid = 1'b0;
        @(negedge Clock);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("final_r%0d", i), 32'(rf[i]), 32'(ref_reg[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command-driven initiator for the dual-read/single-write register file. It accepts one register-level command per handshake and drives the register file read ports. It presents the two operands to the external combinational ALU, captures the ALU result and writes it back through the register file's write port. It sits between the test/control front end and the ALU/register-file pair, and serializes commands so read-after-write ordering is always correct.

## Interface
- DATA_WIDTH, default REGFILE_WIDTH: register and ALU data width
- ADDR_WIDTH, default REGFILE_ADDR_WIDTH: register address width
- OP_WIDTH, default ALU_OP_WIDTH (3): ALU opcode width

- Clock  in  1  rising-edge clock, single clock domain
- Reset  in  1  synchronous, active-high reset
- Cmd_Valid  in  1  command present
- Cmd_Ready  out  1  sequencer can accept a command
- Cmd_Load  in  1  1 = write Cmd_Imm to Cmd_Dst without using the ALU
- Cmd_Op  in  OP_WIDTH  ALU opcode, passed through unchanged
- Cmd_Src1, Cmd_Src2  in  ADDR_WIDTH  operand register addresses
- Cmd_Dst  in  ADDR_WIDTH  destination register address
- Cmd_Imm  in  DATA_WIDTH  immediate for load commands
- Read_Addr_1, Read_Addr_2  out  ADDR_WIDTH  to the register file read ports
- Rd_Data_1, Rd_Data_2  in  DATA_WIDTH  register file read data (combinational read)
- Rf_Write_Addr  out  ADDR_WIDTH  write address
- Rf_Write_Data  out  DATA_WIDTH  write data
- Rf_Write_enable  out  1  write strobe
- Alu_A, Alu_B  out  DATA_WIDTH  ALU operands
- Alu_Op  out  OP_WIDTH  ALU opcode
- Alu_Result  in  DATA_WIDTH  combinational ALU result
- Done  out  1  high for exactly the write-back cycle
- Result  out  DATA_WIDTH  last written value, held until the next write-back

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- **IDLE**
  - Cmd_Ready = 1.
  - On Cmd_Valid & Cmd_Ready, latch all Cmd_* fields.
  - Next state is WB if Cmd_Load, otherwise READ.
- **READ**
  - Read_Addr_1/2 = latched Src1/Src2.
  - Rd_Data_1/2 are captured into the operand registers at the end of the cycle.
  - Next state is EXEC.
- **EXEC**
  - Alu_A/Alu_B/Alu_Op are driven from the operand and opcode registers.
  - Alu_Result is captured into the result register.
  - Next state is WB.
- **WB**
  - Rf_Write_enable = 1, Rf_Write_Addr = latched Dst, Rf_Write_Data = result register (or the latched Imm for a load).
  - Done = 1 and Result is updated.
  - Next state is IDLE.
- Cmd_Ready = (state == IDLE) & !Reset. Commands presented outside IDLE are not consumed; Cmd_Valid may stay high.
- Rf_Write_enable = (state == WB) & !Reset. A reset during WB suppresses the write.
- Src1 == Src2, and Dst equal to either source, are legal. Sources are read before the write.
- Opcode values are not checked. Unknown opcodes pass straight to the ALU.
- Alu_A, Alu_B and Alu_Op are registered and hold their values outside EXEC.
- Read_Addr_1/2 hold their last value outside READ.
- Reset values: state IDLE; operand, opcode, result and Result registers all 0.
  - Read_Addr_1/2 = 0, Rf_Write_Addr = 0, Rf_Write_Data = 0.
  - Done = 0, Rf_Write_enable = 0, Cmd_Ready = 0 while Reset is high.

## Timing
- Accept edge = cycle 0.
- ALU command: READ in cycle 1, EXEC in cycle 2, WB in cycle 3. The register is updated at the end of cycle 3, and Cmd_Ready returns in cycle 4 (4-cycle throughput).
- Load command: WB in cycle 1, Cmd_Ready returns in cycle 2.
- A back-to-back dependent command reads the updated value because its earliest READ is 2 cycles after the prior WB.
- A reset asserted in any state returns the FSM to IDLE at the next edge. The in-flight command is dropped with no write.

## Structure
- Shared package alu_regfile_defs holds:
  - seq_state_t enum {IDLE, READ, EXEC, WB}
  - ALU_OP_WIDTH and alu_op_t
  - a seq_cmd_t packed struct {load, op, src1, src2, dst, imm}
- No sub-module is needed: a single FSM with its datapath registers.
- The top-level wrapper instantiates regfile_sequencer, register_file and the ALU.

## Test plan
Bench ALU model: op 0 = add, op 1 = sub.
- Reset, then load R1 = 8'h05 and R2 = 8'h03 -> Done in cycle 1 of each command, register contents 05 and 03, Result = 03 after the second load.
- Op 0 with Src1 = R1, Src2 = R2, Dst = R3 -> Read_Addr set in cycle 1, Alu_A/B = 05/03 in cycle 2, write of 08 to R3 in cycle 3, Cmd_Ready high in cycle 4.
- Op 1 with Src1 = R3, Src2 = R3, Dst = R3 -> R3 = 00, showing that both operands are read before the write.
- Cmd_Valid held high with two queued dependent commands (R4 = R3 + R1, then R5 = R4 + R4) -> each command is accepted only when Cmd_Ready is high, and R5 = 0A.
- Reset asserted in the WB cycle of an add to R6 -> no write (R6 keeps its prior value), Done = 0, state IDLE, Cmd_Ready = 1 in the cycle after reset deasserts.
- Load R7 = FF, then op 0 with R7 + R7 -> write of FE to R7 (carry discarded, result truncated to DATA_WIDTH).
